axi_burst_master: RTL and testbench

//  Single-outstanding AXI4 master: turns a simple command + data-stream interface into INCR bursts.

---
 rtl/axi_burst_master_pkg.sv | 15 +
 rtl/axi_burst_master_if.sv | 91 +++++++++
 rtl/axi_burst_master.sv | 167 ++++++++++++++++
 tb/tb_axi_burst_master.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_master_pkg.sv
// Shared AXI4 constants and the response-ordering helper for the burst master.
package axi_burst_master_pkg;
    localparam logic [1:0] BURST_INCR        = 2'b01;
    localparam logic [1:0] RESP_OKAY         = 2'd0;
    localparam logic [1:0] RESP_EXOKAY       = 2'd1;
    localparam logic [1:0] RESP_SLVERR       = 2'd2;
    localparam logic [1:0] RESP_DECERR       = 2'd3;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b010;

    // Response codes are ordered by severity, so the worst one is the numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_burst_master_if.sv
// Command/data-stream side plus AXI4 master bus of the burst master, one bundle.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    import axi_burst_master_pkg::*;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  cmd_write;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [1:0]            sts_resp;
    logic                  sts_valid;

    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_addr, cmd_len, cmd_write, cmd_valid, wr_data, wr_strb, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_last, rd_valid, sts_resp, sts_valid,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_write, cmd_valid, wr_data, wr_strb, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_last, rd_valid, sts_resp, sts_valid,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master; W/R data pass through with zero latency.
// Backpressure is combinational both ways; one status pulse per command, next command the cycle after.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic               clk,
    input  logic               rst,
    axi_burst_master_if.master bus
);
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ADDR_LSB) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_WR_RESP, S_RD_DATA} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_beat_cnt;
    logic                  r_awvalid;
    logic                  r_arvalid;
    logic                  r_sts_valid;
    logic [1:0]            r_sts_resp;

    logic       w_cmd_rdy;
    logic       w_wvalid;
    logic       w_wr_rdy;
    logic       w_bready;
    logic       w_rready;
    logic       w_rd_vld;
    logic       w_cnt_last;
    logic       w_cmd_fire;
    logic       w_w_beat;
    logic       w_r_beat;
    logic       w_b_fire;
    logic [1:0] w_beat_resp;
    logic       w_unused;

    assign w_cnt_last = (r_beat_cnt == 8'd0);
    assign w_cmd_fire = w_cmd_rdy && bus.cmd_valid;
    assign w_w_beat   = w_wvalid && w_wr_rdy;
    assign w_r_beat   = w_rd_vld && w_rready;
    assign w_b_fire   = w_bready && bus.m_axi_bvalid;
    // A slave whose rlast disagrees with our beat count has broken the burst.
    assign w_beat_resp = (bus.m_axi_rlast != w_cnt_last) ? resp_max(bus.m_axi_rresp, RESP_SLVERR)
                                                         : bus.m_axi_rresp;
    assign w_unused    = ^{bus.m_axi_bid, bus.m_axi_rid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_wvalid    = 1'b0;
        w_wr_rdy    = 1'b0;
        w_bready    = 1'b0;
        w_rready    = 1'b0;
        w_rd_vld    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_rdy = !r_sts_valid && !rst;
                if (w_cmd_rdy && bus.cmd_valid)
                    w_state_nxt = bus.cmd_write ? S_WR_DATA : S_RD_DATA;
            end
            S_WR_DATA: begin
                w_wvalid = bus.wr_valid;
                w_wr_rdy = bus.m_axi_wready;
                if (bus.wr_valid && bus.m_axi_wready && w_cnt_last)
                    w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                w_bready = !r_awvalid;
                if (w_bready && bus.m_axi_bvalid)
                    w_state_nxt = S_IDLE;
            end
            S_RD_DATA: begin
                // Gating on AR completion guarantees we never leave with arvalid pending.
                w_rd_vld = bus.m_axi_rvalid && !r_arvalid;
                w_rready = bus.rd_ready && !r_arvalid;
                if (w_rd_vld && bus.rd_ready && w_cnt_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_sts_valid <= 1'b0;
            r_sts_resp  <= RESP_OKAY;
            r_beat_cnt  <= 8'd0;
        end else begin
            r_sts_valid <= 1'b0;
            if (w_cmd_fire) begin
                r_awvalid  <= bus.cmd_write;
                r_arvalid  <= !bus.cmd_write;
                r_beat_cnt <= bus.cmd_len;
                r_sts_resp <= RESP_OKAY;
            end else begin
                if (r_awvalid && bus.m_axi_awready) r_awvalid <= 1'b0;
                if (r_arvalid && bus.m_axi_arready) r_arvalid <= 1'b0;
                if (w_w_beat || w_r_beat)           r_beat_cnt <= r_beat_cnt - 8'd1;
                if (w_r_beat) begin
                    r_sts_resp <= resp_max(r_sts_resp, w_beat_resp);
                    if (w_cnt_last) r_sts_valid <= 1'b1;
                end
                if (w_b_fire) begin
                    r_sts_resp  <= bus.m_axi_bresp;
                    r_sts_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_fire) begin
            r_addr <= bus.cmd_addr & ADDR_ALIGN_MASK;
            r_len  <= bus.cmd_len;
        end
    end

    assign bus.cmd_ready     = w_cmd_rdy;
    assign bus.wr_ready      = w_wr_rdy;
    assign bus.rd_data       = bus.m_axi_rdata;
    assign bus.rd_last       = w_cnt_last;
    assign bus.rd_valid      = w_rd_vld;
    assign bus.sts_resp      = r_sts_resp;
    assign bus.sts_valid     = r_sts_valid;

    assign bus.m_axi_awid    = AXI_ID;
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awlen   = r_len;
    assign bus.m_axi_awsize  = 3'(ADDR_LSB);
    assign bus.m_axi_awburst = BURST_INCR;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = AXI_CACHE_DEFAULT;
    assign bus.m_axi_awprot  = AXI_PROT_DEFAULT;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_wdata   = bus.wr_data;
    assign bus.m_axi_wstrb   = bus.wr_strb;
    assign bus.m_axi_wlast   = w_cnt_last;
    assign bus.m_axi_wvalid  = w_wvalid;
    assign bus.m_axi_bready  = w_bready;

    assign bus.m_axi_arid    = AXI_ID;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arlen   = r_len;
    assign bus.m_axi_arsize  = 3'(ADDR_LSB);
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = AXI_CACHE_DEFAULT;
    assign bus.m_axi_arprot  = AXI_PROT_DEFAULT;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = w_rready;
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench: burst master against a stalling AXI memory slave with error injection.
`timescale 1ns/1ps
module tb_axi_burst_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

    axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        logic [31:0] step;
        logic [3:0]  strb;
        int          err_beat;
        logic [1:0]  err_resp;
        logic        bad_last;
        int          aw_delay;
        logic [1:0]  exp_resp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // {id, size, burst, lock, cache, prot} expected on both address channels
    localparam logic [20:0] AX_INFO_EXP = {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010};

    // slave configuration, written by the stimulus only
    int         cfg_err_beat = -1;
    logic [1:0] cfg_err_resp = 2'd0;
    logic       cfg_bad_last = 1'b0;
    int         cfg_aw_delay = 0;

    logic [31:0] mem    [0:1023];
    logic [31:0] wbuf_d [0:255];
    logic [3:0]  wbuf_s [0:255];
    int          s_wcnt, s_wlast_idx, s_last_wlast_idx, s_last_wbeats, s_aw_wait, s_rbeat;
    logic        s_aw_have, s_w_done, s_ar_have, s_bready_early;
    logic [15:0] s_aw_addr, s_ar_addr;
    logic [7:0]  s_aw_len, s_ar_len;
    logic [20:0] s_aw_info, s_ar_info;

    always @(posedge clk or posedge rst) begin : slave
        int          nb;
        logic [31:0] mw;
        if (rst) begin
            bus.m_axi_awready <= 1'b0;  bus.m_axi_wready <= 1'b0;
            bus.m_axi_bvalid  <= 1'b0;  bus.m_axi_bresp  <= 2'd0;  bus.m_axi_bid <= 8'd0;
            bus.m_axi_arready <= 1'b0;  bus.m_axi_rvalid <= 1'b0;  bus.m_axi_rdata <= 32'd0;
            bus.m_axi_rresp   <= 2'd0;  bus.m_axi_rlast  <= 1'b0;  bus.m_axi_rid <= 8'd0;
            s_wcnt <= 0;  s_wlast_idx <= -1;  s_aw_wait <= 0;  s_rbeat <= 0;
            s_aw_have <= 1'b0;  s_w_done <= 1'b0;  s_ar_have <= 1'b0;  s_bready_early <= 1'b0;
        end else begin
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                bus.m_axi_awready <= 1'b0;
                s_aw_have <= 1'b1;
                s_aw_wait <= 0;
                s_aw_addr <= bus.m_axi_awaddr;
                s_aw_len  <= bus.m_axi_awlen;
                s_aw_info <= {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst,
                              bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot};
            end else if (bus.m_axi_awvalid && !s_aw_have) begin
                if (s_aw_wait >= cfg_aw_delay) bus.m_axi_awready <= 1'b1;
                else                           s_aw_wait <= s_aw_wait + 1;
            end

            bus.m_axi_wready <= ($urandom_range(3) != 0);
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                wbuf_d[s_wcnt] <= bus.m_axi_wdata;
                wbuf_s[s_wcnt] <= bus.m_axi_wstrb;
                s_wcnt <= s_wcnt + 1;
                if (bus.m_axi_wlast) begin
                    s_w_done <= 1'b1;
                    if (s_wlast_idx < 0) s_wlast_idx <= s_wcnt;
                end
            end
            if (bus.m_axi_bready && bus.m_axi_awvalid) s_bready_early <= 1'b1;

            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                bus.m_axi_bvalid <= 1'b0;
                s_aw_have <= 1'b0;  s_w_done <= 1'b0;  s_wcnt <= 0;
                s_last_wlast_idx <= s_wlast_idx;
                s_last_wbeats    <= s_wcnt;
                s_wlast_idx      <= -1;
            end else if (s_aw_have && s_w_done && !bus.m_axi_bvalid) begin
                for (int k = 0; k < s_wcnt; k++) begin
                    mw = mem[s_aw_addr[11:2] + 10'(k)];
                    for (int j = 0; j < 4; j++)
                        if (wbuf_s[k][j]) mw[j*8 +: 8] = wbuf_d[k][j*8 +: 8];
                    mem[s_aw_addr[11:2] + 10'(k)] <= mw;
                end
                bus.m_axi_bvalid <= 1'b1;
                bus.m_axi_bresp  <= (cfg_err_beat >= 0) ? cfg_err_resp : 2'd0;
            end

            nb = s_rbeat;
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                nb = s_rbeat + 1;
                bus.m_axi_rvalid <= 1'b0;
                if (s_rbeat == int'(s_ar_len)) s_ar_have <= 1'b0;
            end
            s_rbeat <= nb;
            if (s_ar_have && nb <= int'(s_ar_len) && (!bus.m_axi_rvalid || bus.m_axi_rready)
                && ($urandom_range(3) != 0)) begin
                bus.m_axi_rvalid <= 1'b1;
                bus.m_axi_rdata  <= mem[s_ar_addr[11:2] + 10'(nb)];
                bus.m_axi_rresp  <= (nb == cfg_err_beat) ? cfg_err_resp : 2'd0;
                bus.m_axi_rlast  <= cfg_bad_last ? 1'b0 : (nb == int'(s_ar_len));
            end

            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                bus.m_axi_arready <= 1'b0;
                s_ar_have <= 1'b1;
                s_rbeat   <= 0;
                s_ar_addr <= bus.m_axi_araddr;
                s_ar_len  <= bus.m_axi_arlen;
                s_ar_info <= {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst,
                              bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot};
            end else if (bus.m_axi_arvalid && !s_ar_have) begin
                bus.m_axi_arready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                                input logic [31:0] d0, input logic [31:0] step, input logic [3:0] strb,
                                input int err_beat, input logic [1:0] err_resp, input logic bad_last,
                                input int aw_delay, input logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr;  v.addr = addr;  v.len = len;  v.d0 = d0;  v.step = step;  v.strb = strb;
        v.err_beat = err_beat;  v.err_resp = err_resp;  v.bad_last = bad_last;
        v.aw_delay = aw_delay;  v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len, input string nm);
        int t;
        @(negedge clk);
        bus.cmd_addr = addr;  bus.cmd_len = len;  bus.cmd_write = wr;  bus.cmd_valid = 1'b1;
        t = 0;
        #1;
        while (!bus.cmd_ready && t < 200) begin @(negedge clk); #1; t++; end
        if (t >= 200) check({nm, "_cmd_timeout"}, 64'(t), 64'(0));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          t, beats;
        logic        saw, tmo;
        logic [31:0] expd;
        string       nm;
        nm = $sformatf("v%0d", id);
        cfg_err_beat = v.err_beat;  cfg_err_resp = v.err_resp;
        cfg_bad_last = v.bad_last;  cfg_aw_delay = v.aw_delay;
        issue_cmd(v.wr, v.addr, v.len, nm);
        tmo = 1'b0;
        if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                bus.wr_data  = v.d0 + 32'(i) * v.step;
                bus.wr_strb  = v.strb;
                bus.wr_valid = 1'b1;
                t = 0;
                #1;
                while (!bus.wr_ready && t < 500) begin @(negedge clk); #1; t++; end
                if (t >= 500) tmo = 1'b1;
                @(negedge clk);
            end
            bus.wr_valid = 1'b0;
        end
        t = 0;  saw = 1'b0;  beats = 0;
        while (!saw && t < 2000) begin
            if (!v.wr) bus.rd_ready = ($urandom_range(3) != 0);
            #1;
            if (bus.rd_valid && bus.rd_ready) begin
                expd = v.d0 + 32'(beats) * v.step;
                check({nm, "_rd_data"}, 64'(bus.rd_data), 64'(expd));
                check({nm, "_rd_last"}, 64'(bus.rd_last), 64'(beats == int'(v.len)));
                beats++;
            end
            if (bus.sts_valid) begin
                saw = 1'b1;
                check({nm, "_sts_resp"}, 64'(bus.sts_resp), 64'(v.exp_resp));
                check({nm, "_cmd_rdy_in_pulse"}, 64'(bus.cmd_ready), 64'(0));
            end
            @(negedge clk);
            t++;
        end
        bus.rd_ready = 1'b1;
        check({nm, "_timeout"}, 64'({tmo, !saw}), 64'(0));
        #1;
        check({nm, "_sts_single_pulse"}, 64'(bus.sts_valid), 64'(0));
        check({nm, "_cmd_rdy_after"}, 64'(bus.cmd_ready), 64'(1));
        if (v.wr) begin
            check({nm, "_aw"}, {19'd0, s_aw_addr, s_aw_len, s_aw_info},
                  {19'd0, v.addr & 16'hFFFC, v.len, AX_INFO_EXP});
            check({nm, "_wlast_beat"}, 64'(s_last_wlast_idx), 64'(v.len));
            check({nm, "_w_beats"}, 64'(s_last_wbeats), 64'(int'(v.len) + 1));
        end else begin
            check({nm, "_ar"}, {19'd0, s_ar_addr, s_ar_len, s_ar_info},
                  {19'd0, v.addr & 16'hFFFC, v.len, AX_INFO_EXP});
            check({nm, "_rd_beats"}, 64'(beats), 64'(int'(v.len) + 1));
        end
    endtask

    function automatic logic [8:0] all_valids();
        return {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                bus.m_axi_arvalid, bus.m_axi_rready, bus.rd_valid, bus.sts_valid, |bus.sts_resp};
    endfunction

    vec_t vecs [0:13];

    initial begin
        int t, beats;
        vecs[0]  = mk(1, 16'h0100, 3, 32'h11,       32'h11,  4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[1]  = mk(0, 16'h0100, 3, 32'h11,       32'h11,  4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[2]  = mk(1, 16'h0200, 0, 32'hFFFFFFFF, 32'h0,   4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[3]  = mk(1, 16'h0200, 0, 32'h12AA34BB, 32'h0,   4'h5, -1, 2'd0, 0, 0,  2'd0);
        vecs[4]  = mk(0, 16'h0200, 0, 32'hFFAAFFBB, 32'h0,   4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[5]  = mk(1, 16'h0300, 3, 32'hA0,       32'h100, 4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[6]  = mk(0, 16'h0300, 3, 32'hA0,       32'h100, 4'hF,  1, 2'd2, 0, 0,  2'd2);
        vecs[7]  = mk(0, 16'h0300, 3, 32'hA0,       32'h100, 4'hF,  0, 2'd1, 0, 0,  2'd1);
        vecs[8]  = mk(0, 16'h0100, 1, 32'h11,       32'h11,  4'hF, -1, 2'd0, 1, 0,  2'd2);
        vecs[9]  = mk(1, 16'h0500, 1, 32'h5,        32'h1,   4'hF,  0, 2'd3, 0, 0,  2'd3);
        vecs[10] = mk(1, 16'h0600, 2, 32'hC0DE0000, 32'h1,   4'hF, -1, 2'd0, 0, 10, 2'd0);
        vecs[11] = mk(0, 16'h0600, 2, 32'hC0DE0000, 32'h1,   4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[12] = mk(1, 16'h0403, 7, 32'h1000,     32'h1,   4'hF, -1, 2'd0, 0, 0,  2'd0);
        vecs[13] = mk(0, 16'h0401, 7, 32'h1000,     32'h1,   4'hF, -1, 2'd0, 0, 0,  2'd0);

        bus.cmd_addr = '0;  bus.cmd_len = '0;  bus.cmd_write = 1'b0;  bus.cmd_valid = 1'b0;
        bus.wr_data  = '0;  bus.wr_strb = '0;  bus.wr_valid  = 1'b0;  bus.rd_ready  = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        check("reset_outputs", 64'(all_valids()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_cmd_rdy", 64'(all_valids()), 64'(9'h100));

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
            if (i == 10) check("v10_bready_before_aw", 64'(s_bready_early), 64'(0));
        end

        // abort an 8-beat read after two beats
        cfg_err_beat = -1;  cfg_bad_last = 1'b0;  cfg_aw_delay = 0;
        issue_cmd(1'b0, 16'h0400, 8'd7, "rst_rd");
        bus.rd_ready = 1'b1;
        beats = 0;  t = 0;
        while (beats < 2 && t < 500) begin
            #1;
            if (bus.rd_valid) begin
                check("rst_rd_data", 64'(bus.rd_data), 64'(32'h1000 + 32'(beats)));
                beats++;
            end
            @(negedge clk);
            t++;
        end
        check("rst_rd_two_beats", 64'(beats), 64'(2));
        rst = 1'b1;
        #1;
        check("rst_mid_read_outputs", 64'(all_valids()), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_read_release", 64'(all_valids()), 64'(9'h100));
        run_vec(vecs[1], 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
